// File: rtl/jpeg_bit_reader.sv
// JPEG entropy-coded segment bit reader.
// Accepts scan bytes, removes 0xFF00 byte stuffing, skips 0xFF fill bytes,
// detects markers, and presents an MSB-first bit buffer from which the
// decoder peeks up to 16 bits and consumes 1..16 bits per cycle.
//
// Handshake: a byte moves on a rising clk edge when in_valid and in_ready
// are both high; in_valid may be held while in_ready is low and the byte is
// simply taken on a later edge. in_ready is purely combinational.
module jpeg_bit_reader #(
    parameter int BUF_W = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [15:0] peek_bits,
    output logic [5:0]  avail_bits,
    input  logic        consume_en,
    input  logic [4:0]  consume_len,
    output logic        consume_err,
    input  logic        flush,
    output logic        marker_valid,
    output logic [7:0]  marker_code,
    input  logic        marker_ack
);

    typedef enum logic [1:0] {
        NORMAL = 2'd0,
        GOT_FF = 2'd1,
        MARKER = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [BUF_W-1:0] buf_q, buf_d;
    logic [5:0]       avail_q, avail_d;
    logic             marker_valid_q, marker_valid_d;
    logic [7:0]       marker_code_q, marker_code_d;
    logic             consume_err_q, consume_err_d;

    logic             xfer;
    logic             consume_legal;
    logic             append_en;
    logic [7:0]       append_byte;
    logic [BUF_W-1:0] buf_mid;
    logic [5:0]       avail_mid;

    // Room for a full byte is needed before a transfer is offered; the
    // buffer never overflows because at most 8 bits are added per edge.
    assign in_ready = !rst && !flush && (state_q != MARKER) && (avail_q <= 6'd24);
    assign xfer     = in_valid && in_ready;

    assign consume_legal = (consume_len != 5'd0) && (consume_len <= 5'd16)
                         && ({1'b0, consume_len} <= avail_q);

    assign peek_bits    = buf_q[BUF_W-1 -: 16];
    assign avail_bits   = avail_q;
    assign marker_valid = marker_valid_q;
    assign marker_code  = marker_code_q;
    assign consume_err  = consume_err_q;

    // Byte-level FSM: decides whether a transferred byte adds data bits,
    // is swallowed as 0xFF prefix/fill, or terminates the segment as a marker.
    always_comb begin
        state_d        = state_q;
        append_en      = 1'b0;
        append_byte    = in_data;
        marker_valid_d = marker_valid_q;
        marker_code_d  = marker_code_q;
        case (state_q)
            NORMAL: begin
                if (xfer) begin
                    if (in_data == 8'hFF) begin
                        state_d = GOT_FF;
                    end else begin
                        append_en = 1'b1;
                    end
                end
            end
            GOT_FF: begin
                if (xfer) begin
                    if (in_data == 8'h00) begin
                        // Stuffed zero: the preceding 0xFF was real data.
                        append_en   = 1'b1;
                        append_byte = 8'hFF;
                        state_d     = NORMAL;
                    end else if (in_data != 8'hFF) begin
                        marker_code_d  = in_data;
                        marker_valid_d = 1'b1;
                        state_d        = MARKER;
                    end
                end
            end
            MARKER: begin
                if (marker_ack) begin
                    marker_valid_d = 1'b0;
                    state_d        = NORMAL;
                end
            end
            default: begin
                state_d = NORMAL;
            end
        endcase
    end

    // Buffer datapath: flush or consume first, then append the new byte
    // directly below the surviving bits so lower bits stay zero-filled.
    always_comb begin
        buf_mid       = buf_q;
        avail_mid     = avail_q;
        consume_err_d = 1'b0;
        if (flush) begin
            buf_mid   = '0;
            avail_mid = 6'd0;
        end else if (consume_en) begin
            if (consume_legal) begin
                buf_mid   = buf_q << consume_len;
                avail_mid = avail_q - {1'b0, consume_len};
            end else begin
                consume_err_d = 1'b1;
            end
        end
        buf_d   = buf_mid;
        avail_d = avail_mid;
        if (append_en) begin
            buf_d   = buf_mid | ({append_byte, {(BUF_W-8){1'b0}}} >> avail_mid);
            avail_d = avail_mid + 6'd8;
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= NORMAL;
            buf_q          <= '0;
            avail_q        <= 6'd0;
            marker_valid_q <= 1'b0;
            marker_code_q  <= 8'h00;
            consume_err_q  <= 1'b0;
        end else begin
            state_q        <= state_d;
            buf_q          <= buf_d;
            avail_q        <= avail_d;
            marker_valid_q <= marker_valid_d;
            marker_code_q  <= marker_code_d;
            consume_err_q  <= consume_err_d;
        end
    end

endmodule

// File: tb/tb_jpeg_bit_reader.sv
// Bench for jpeg_bit_reader: directed scenarios followed by random traffic,
// checked against a bit-queue reference model through an expected queue.
module tb_jpeg_bit_reader;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] peek_bits;
    logic [5:0]  avail_bits;
    logic        consume_en;
    logic [4:0]  consume_len;
    logic        consume_err;
    logic        flush;
    logic        marker_valid;
    logic [7:0]  marker_code;
    logic        marker_ack;

    int tests = 0;
    int fails = 0;

    typedef struct packed {
        logic        ready;
        logic [5:0]  avail;
        logic [15:0] peek;
        logic        mv;
        logic [7:0]  mcode;
        logic        err;
    } exp_t;

    exp_t exp_q[$];

    // Reference model: buffered bits as a plain queue, oldest first.
    bit         m_bits[$];
    bit         m_pending;
    bit         m_held;
    logic [7:0] m_code;
    bit         m_err;

    jpeg_bit_reader #(.BUF_W(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .peek_bits    (peek_bits),
        .avail_bits   (avail_bits),
        .consume_en   (consume_en),
        .consume_len  (consume_len),
        .consume_err  (consume_err),
        .flush        (flush),
        .marker_valid (marker_valid),
        .marker_code  (marker_code),
        .marker_ack   (marker_ack)
    );

    // Clock and initial input values.
    always #5 clk = ~clk;

    initial begin
        rst = 1'b1; in_data = 8'h00; in_valid = 1'b0; consume_en = 1'b0;
        consume_len = 5'd0; flush = 1'b0; marker_ack = 1'b0;
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
        end
    endtask

    // Driver: applies one cycle of inputs and pushes the model's prediction.
    task automatic drive(input logic r, input logic f, input logic v, input logic [7:0] d,
                         input logic ce, input logic [4:0] cl, input logic ack);
        exp_t       e;
        int         n;
        bit         add;
        logic [7:0] abyte;
        @(negedge clk);
        rst = r; flush = f; in_valid = v; in_data = d;
        consume_en = ce; consume_len = cl; marker_ack = ack;
        add = 0;
        abyte = d;
        if (r) begin
            e.ready = 1'b0;
            m_bits.delete();
            m_pending = 0; m_held = 0; m_code = 8'h00; m_err = 0;
        end else begin
            n = m_bits.size();
            e.ready = !f && !m_held && (n <= 24);
            m_err = 0;
            if (m_held) begin
                if (ack) m_held = 0;
            end else if (v && e.ready) begin
                if (m_pending) begin
                    if (d == 8'h00) begin
                        add = 1; abyte = 8'hFF; m_pending = 0;
                    end else if (d != 8'hFF) begin
                        m_held = 1; m_code = d; m_pending = 0;
                    end
                end else if (d == 8'hFF) begin
                    m_pending = 1;
                end else begin
                    add = 1;
                end
            end
            if (f) begin
                m_bits.delete();
            end else if (ce) begin
                if (cl >= 1 && cl <= 16 && int'(cl) <= n) begin
                    for (int k = 0; k < int'(cl); k++) void'(m_bits.pop_front());
                end else begin
                    m_err = 1;
                end
            end
            if (add) begin
                for (int i = 7; i >= 0; i--) m_bits.push_back(abyte[i]);
            end
        end
        e.avail = 6'(m_bits.size());
        for (int i = 0; i < 16; i++) e.peek[15-i] = (i < m_bits.size()) ? m_bits[i] : 1'b0;
        e.mv    = m_held;
        e.mcode = m_code;
        e.err   = m_err;
        exp_q.push_back(e);
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 5'd0, 1'b0);
    endtask

    task automatic send(input logic [7:0] d);
        drive(1'b0, 1'b0, 1'b1, d, 1'b0, 5'd0, 1'b0);
    endtask

    task automatic do_flush();
        drive(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 5'd0, 1'b0);
    endtask

    // Directed check of registered outputs just after the edge.
    task automatic expect_now(input string name, input logic [5:0] av,
                              input logic [15:0] pk, input logic mv);
        @(posedge clk);
        #1;
        chk({name, ".avail"}, 32'(avail_bits), 32'(av));
        chk({name, ".peek"}, 32'(peek_bits), 32'(pk));
        chk({name, ".marker_valid"}, 32'(marker_valid), 32'(mv));
    endtask

    // Monitor: in_ready is checked late in the driven cycle, registered
    // outputs just after the following edge.
    initial begin
        exp_t e;
        logic got_ready;
        forever begin
            @(negedge clk);
            #4;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                got_ready = in_ready;
                @(posedge clk);
                #1;
                chk("in_ready", 32'(got_ready), 32'(e.ready));
                chk("avail_bits", 32'(avail_bits), 32'(e.avail));
                chk("peek_bits", 32'(peek_bits), 32'(e.peek));
                chk("marker_valid", 32'(marker_valid), 32'(e.mv));
                chk("marker_code", 32'(marker_code), 32'(e.mcode));
                chk("consume_err", 32'(consume_err), 32'(e.err));
            end
        end
    end

    // Stimulus: reset, directed scenarios, random traffic, report.
    initial begin
        logic [7:0] d;
        int         sel;
        drive(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 5'd0, 1'b0);
        drive(1'b1, 1'b1, 1'b1, 8'hFF, 1'b1, 5'd4, 1'b1);
        expect_now("reset", 6'd0, 16'h0000, 1'b0);
        chk("reset.marker_code", 32'(marker_code), 32'h00);

        send(8'hA5);
        send(8'h3C);
        expect_now("two_bytes", 6'd16, 16'hA53C, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 5'd4, 1'b0);
        expect_now("consume4", 6'd12, 16'h53C0, 1'b0);
        do_flush();

        send(8'hFF);
        send(8'h00);
        send(8'h12);
        expect_now("unstuff", 6'd16, 16'hFF12, 1'b0);
        do_flush();

        send(8'h81);
        send(8'hFF);
        send(8'hD9);
        expect_now("marker", 6'd8, 16'h8100, 1'b1);
        chk("marker.code", 32'(marker_code), 32'hD9);
        chk("marker.in_ready", 32'(in_ready), 32'd0);
        idle();
        drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 5'd0, 1'b1);
        expect_now("marker_ack", 6'd8, 16'h8100, 1'b0);
        do_flush();

        send(8'h11);
        send(8'h22);
        send(8'h33);
        send(8'h44);
        expect_now("full", 6'd32, 16'h1122, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 8'h55, 1'b1, 5'd8, 1'b0);
        expect_now("full_consume", 6'd24, 16'h2233, 1'b0);
        send(8'h55);
        expect_now("full_refill", 6'd32, 16'h2233, 1'b0);
        do_flush();

        send(8'h5A);
        drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 5'd9, 1'b0);
        expect_now("consume9", 6'd8, 16'h5A00, 1'b0);
        chk("consume9.err", 32'(consume_err), 32'd1);
        drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 5'd0, 1'b0);
        expect_now("consume0", 6'd8, 16'h5A00, 1'b0);
        chk("consume0.err", 32'(consume_err), 32'd1);
        idle();
        do_flush();

        send(8'hFF);
        drive(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 5'd0, 1'b0);
        send(8'h00);
        expect_now("rst_drops_ff", 6'd8, 16'h0000, 1'b0);

        for (int c = 0; c < 3000; c++) begin
            sel = $urandom_range(0, 9);
            if (sel == 0)      d = 8'hFF;
            else if (sel == 1) d = 8'h00;
            else if (sel == 2) d = 8'(8'hD0 + $urandom_range(0, 9));
            else               d = 8'($urandom_range(0, 255));
            drive(($urandom_range(0, 199) == 0),
                  ($urandom_range(0, 49) == 0),
                  ($urandom_range(0, 3) != 0),
                  d,
                  ($urandom_range(0, 2) == 0),
                  5'($urandom_range(0, 20)),
                  m_held ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 9) == 0));
        end
        idle();
        idle();
        @(posedge clk);
        #2;
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/jpeg_bit_reader.md
JPEG_BIT_READER -- requirements
Module: jpeg_bit_reader

Interface
REQ-001 SHALL have parameter BUF_W, default 32, meaning bit-buffer depth in bits; only the value 32 is supported.
REQ-002 SHALL have port clk, input, 1 bit, the sole clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit; reset is synchronous and active-high.
REQ-004 SHALL have port in_data, input, 8 bits, the next entropy-coded scan byte from the compressed stream.
REQ-005 SHALL have port in_valid, input, 1 bit; in_data is valid.
REQ-006 SHALL have port in_ready, output, 1 bit; the block accepts in_data this cycle.
REQ-007 SHALL have port peek_bits, output, 16 bits; the oldest 16 buffered bits, MSB-first, with zero fill below avail_bits.
REQ-008 SHALL have port avail_bits, output, 6 bits; number of valid buffered bits, 0..32.
REQ-009 SHALL have port consume_en, input, 1 bit; request to drop bits from the head of the buffer.
REQ-010 SHALL have port consume_len, input, 5 bits; number of bits to drop, legal range 1..16.
REQ-011 SHALL have port consume_err, output, 1 bit; one-cycle pulse when a consume request is illegal.
REQ-012 SHALL have port flush, input, 1 bit; discard all buffered bits.
REQ-013 SHALL have port marker_valid, output, 1 bit; a marker was detected and is held.
REQ-014 SHALL have port marker_code, output, 8 bits; the second byte of the detected marker.
REQ-015 SHALL have port marker_ack, input, 1 bit; the consumer has taken the marker.

Function
REQ-016 SHALL perform the byte transfer when in_valid and in_ready are both high on a rising clk edge.
REQ-017 SHALL drive in_ready = !rst && !flush && state!=MARKER && avail_bits<=24, computed combinationally.
REQ-018 SHALL implement the state machine NORMAL, GOT_FF and MARKER.
REQ-019 In NORMAL, on a transferred byte != 0xFF, SHALL append its 8 bits; on 0xFF SHALL append nothing and go to GOT_FF.
REQ-020 In GOT_FF, on byte 0x00 SHALL append 0xFF and go to NORMAL (stuffing removal).
REQ-021 In GOT_FF, on byte 0xFF SHALL append nothing and stay in GOT_FF (fill byte).
REQ-022 In GOT_FF, on any other byte SHALL load marker_code, set marker_valid and go to MARKER.
REQ-023 In MARKER, SHALL keep buffered bits readable and consumable; marker_ack SHALL clear marker_valid and return to NORMAL on the next edge.
REQ-024 SHALL make an appended byte visible on peek_bits and avail_bits in the cycle after the transfer (latency 1).
REQ-025 A consume is legal when 1<=consume_len<=16 and consume_len<=avail_bits; a legal consume SHALL shift the head left by consume_len on the next edge.
REQ-026 An illegal consume SHALL leave the buffer unchanged and pulse consume_err high for the next cycle.
REQ-027 On a simultaneous consume and append, SHALL apply the consume first, then place the byte immediately after the remaining bits: new avail = avail - len + 8.
REQ-028 flush SHALL set avail_bits to 0 and the buffer to 0; it SHALL NOT change state, marker_valid or marker_code; a concurrent consume SHALL be ignored without raising consume_err.
REQ-029 SHALL keep all bits below avail_bits at 0 so that peek_bits zero-fills.

Reset
REQ-030 On rst SHALL set state=NORMAL, the buffer to 0, avail_bits=0, peek_bits=0, marker_valid=0, marker_code=0x00 and consume_err=0; in_ready SHALL be 0 during rst and 1 in the first cycle after.
REQ-031 rst SHALL override flush, consume_en and any transfer in the same cycle; a pending GOT_FF SHALL be discarded.

Verification
REQ-032 Bench SHALL drive bytes 0xA5, 0x3C -> avail=16, peek=0xA53C; then consume 4 -> peek=0x53C0, avail=12.
REQ-033 Bench SHALL drive bytes 0xFF, 0x00, 0x12 -> avail=16, peek=0xFF12, marker_valid stays 0.
REQ-034 Bench SHALL drive bytes 0x81, 0xFF, 0xD9 -> marker_valid=1, marker_code=0xD9, in_ready=0, avail=8, peek=0x8100; then marker_ack -> marker_valid=0, in_ready=1.
REQ-035 Bench SHALL drive 4 non-0xFF bytes -> avail=32, in_ready=0; then consume 8 together with a held byte -> avail=24, in_ready=1, and the byte is accepted next -> avail=32.
REQ-036 Bench SHALL issue consume 9 with avail=8, then consume 0 -> consume_err pulses for each, buffer unchanged.
REQ-037 Bench SHALL drive 0xFF, then rst, then 0x00 -> 0x00 is appended as data, avail=8, peek=0x0000, no marker.
